// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle, with HI/LO results.
// Optional MULDIV_ZERO_REG_GUARD_EN suppresses the write strobe when the destination is register 0.
module mul_div_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result_lo,
  output logic [WIDTH-1:0]  result_hi,
  output logic [ADDR_W-1:0] write_addr,
  output logic              reg_write,
  output logic [WIDTH-1:0]  wb_data
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] work;
  logic [2*WIDTH-1:0] step_nxt;
  logic [WIDTH-1:0]   operand_q;
  logic [WIDTH-1:0]   dividend_q;
  logic [ADDR_W-1:0]  dest_q;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               div_zero;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;

  logic               accept;
  logic               b_zero;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  assign accept = start && (state == IDLE || state == DONE);
  assign b_zero = (operand_b == '0);
  assign sign_a = op[0] && operand_a[WIDTH-1];
  assign sign_b = op[0] && operand_b[WIDTH-1];
  assign mag_a  = sign_a ? -operand_a : operand_a;
  assign mag_b  = sign_b ? -operand_b : operand_b;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (op[1] && b_zero) ? FIX : CALC;
        else       state_nxt = IDLE;
      end
      CALC: begin
        if (flush)             state_nxt = IDLE;
        else if (cnt == LAST)  state_nxt = FIX;
      end
      FIX:     state_nxt = flush ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // work holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, operand_q} : '0);
    div_shift = work[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, operand_q};
    if (is_div) begin
      if (div_diff[WIDTH]) step_nxt = {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
      else                 step_nxt = {div_diff[WIDTH-1:0],  work[WIDTH-2:0], 1'b1};
    end else begin
      step_nxt = {mul_sum, work[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_res ? -work : work;
    quo_fix  = div_zero ? '1 : (neg_res ? -work[WIDTH-1:0] : work[WIDTH-1:0]);
    rem_fix  = div_zero ? dividend_q
                        : (neg_rem ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work       <= '0;
      operand_q  <= '0;
      dividend_q <= '0;
      dest_q     <= '0;
      cnt        <= '0;
      is_div     <= 1'b0;
      div_zero   <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
    end else if (accept) begin
      is_div     <= op[1];
      div_zero   <= op[1] && b_zero;
      neg_res    <= sign_a ^ sign_b;
      neg_rem    <= sign_a;
      dividend_q <= operand_a;
      dest_q     <= dest_addr;
      cnt        <= '0;
      operand_q  <= op[1] ? mag_b : mag_a;
      work       <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
    end else if (state == CALC) begin
      cnt  <= cnt + 1'b1;
      work <= step_nxt;
    end else if (state == FIX && !flush) begin
      if (is_div) begin
        lo_q <= quo_fix;
        hi_q <= rem_fix;
      end else begin
        lo_q <= prod_fix[WIDTH-1:0];
        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign busy       = (state == CALC) || (state == FIX);
  assign done       = (state == DONE);
  assign result_lo  = lo_q;
  assign result_hi  = hi_q;
  assign wb_data    = lo_q;
  assign write_addr = dest_q;
`ifdef MULDIV_ZERO_REG_GUARD_EN
  assign reg_write  = done && (dest_q != '0);
`else
  assign reg_write  = done;
`endif

endmodule
